// File: rtl/laser_tx_framer.sv
// laser_tx_framer: buffers host bytes in a small FIFO and serialises each one
// as a start bit, eight data bits (LSB first) and STOP_BITS stop bits. Bits
// advance on rising edges of bit_clk, which is sampled as an enable in the
// clk_base domain.
module laser_tx_framer #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned STOP_BITS  = 1,
    parameter logic        IDLE_LEVEL = 1'b0
) (
    input  logic                   clk_base,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   bit_clk,
    input  logic [7:0]             data_in,
    input  logic                   data_valid,
    output logic                   data_ready,
    output logic                   laser_out,
    output logic                   busy,
    output logic                   tx_done,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [2:0]  STOP_LAST  = 3'(STOP_BITS);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic          bit_clk_q;
    logic          laser_q, laser_d;
    logic          tx_done_q, tx_done_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [2:0]    stop_cnt_q, stop_cnt_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [7:0]    mem_q [DEPTH];

    logic tick;
    logic push;
    logic pop;
    logic fifo_empty;

    assign tick       = bit_clk & ~bit_clk_q;
    assign fifo_empty = (count_q == '0);
    assign data_ready = (count_q != FULL_COUNT);
    assign push       = data_valid & data_ready;

    assign laser_out  = laser_q;
    assign busy       = (state_q != ST_IDLE);
    assign tx_done    = tx_done_q;
    assign fifo_count = count_q;

    // Frame sequencer: a dropped enable aborts the frame immediately, otherwise
    // the state advances one bit per tick; STOP chains straight into the next
    // frame when a byte is waiting.
    always_comb begin
        state_d    = state_q;
        laser_d    = laser_q;
        tx_done_d  = 1'b0;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        stop_cnt_d = stop_cnt_q;
        pop        = 1'b0;

        if (!en && (state_q != ST_IDLE)) begin
            state_d    = ST_IDLE;
            laser_d    = IDLE_LEVEL;
            shift_d    = '0;
            bit_idx_d  = '0;
            stop_cnt_d = '0;
        end else if (tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (en && !fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        laser_d = ~IDLE_LEVEL;
                        state_d = ST_START;
                    end else begin
                        laser_d = IDLE_LEVEL;
                    end
                end
                ST_START: begin
                    laser_d   = shift_q[0];
                    bit_idx_d = '0;
                    state_d   = ST_DATA;
                end
                ST_DATA: begin
                    if (bit_idx_q != 3'd7) begin
                        shift_d   = {1'b0, shift_q[7:1]};
                        laser_d   = shift_q[1];
                        bit_idx_d = bit_idx_q + 3'd1;
                    end else begin
                        laser_d    = IDLE_LEVEL;
                        stop_cnt_d = 3'd1;
                        state_d    = ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (stop_cnt_q < STOP_LAST) begin
                        stop_cnt_d = stop_cnt_q + 3'd1;
                    end else begin
                        tx_done_d  = 1'b1;
                        stop_cnt_d = '0;
                        bit_idx_d  = '0;
                        if (en && !fifo_empty) begin
                            pop     = 1'b1;
                            shift_d = mem_q[rd_ptr_q];
                            laser_d = ~IDLE_LEVEL;
                            state_d = ST_START;
                        end else begin
                            shift_d = '0;
                            laser_d = IDLE_LEVEL;
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: begin
                    laser_d = IDLE_LEVEL;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // FIFO bookkeeping: pointers wrap naturally at DEPTH, and a simultaneous
    // push and pop leaves the occupancy unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // FIFO storage; stale entries are harmless because occupancy gates reads.
    always_ff @(posedge clk_base) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    // State, datapath and FIFO registers with asynchronous reset.
    always_ff @(posedge clk_base or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            bit_clk_q  <= 1'b0;
            laser_q    <= IDLE_LEVEL;
            tx_done_q  <= 1'b0;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            stop_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            bit_clk_q  <= bit_clk;
            laser_q    <= laser_d;
            tx_done_q  <= tx_done_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            stop_cnt_q <= stop_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

endmodule

// File: tb/tb_laser_tx_framer.sv
// Directed testbench for laser_tx_framer: a default instance (DEPTH=4,
// STOP_BITS=1, IDLE_LEVEL=0) and a second instance with two high stop bits.
module tb_laser_tx_framer;

    logic       clk_base;
    logic       reset;
    logic       en;
    logic       bit_clk;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic       laser_out;
    logic       busy;
    logic       tx_done;
    logic [2:0] fifo_count;

    logic [7:0] data_in2;
    logic       data_valid2;
    logic       data_ready2;
    logic       laser_out2;
    logic       busy2;
    logic       tx_done2;
    logic [2:0] fifo_count2;

    int tests;
    int failed;
    int done_cnt  = 0;
    int done_cnt2 = 0;
    int base;
    int base2;
    logic [63:0] bits;
    logic [63:0] bits2;

    laser_tx_framer #(.DEPTH(4), .STOP_BITS(1), .IDLE_LEVEL(1'b0)) dut (
        .clk_base   (clk_base),
        .reset      (reset),
        .en         (en),
        .bit_clk    (bit_clk),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .laser_out  (laser_out),
        .busy       (busy),
        .tx_done    (tx_done),
        .fifo_count (fifo_count)
    );

    laser_tx_framer #(.DEPTH(4), .STOP_BITS(2), .IDLE_LEVEL(1'b1)) dut2 (
        .clk_base   (clk_base),
        .reset      (reset),
        .en         (en),
        .bit_clk    (bit_clk),
        .data_in    (data_in2),
        .data_valid (data_valid2),
        .data_ready (data_ready2),
        .laser_out  (laser_out2),
        .busy       (busy2),
        .tx_done    (tx_done2),
        .fifo_count (fifo_count2)
    );

    // System clock, 10 time units per cycle.
    initial clk_base = 1'b0;
    always #5 clk_base = ~clk_base;

    // Count tx_done pulses mid-cycle so pulse width shows up in the totals.
    always @(negedge clk_base) begin
        if (tx_done === 1'b1) done_cnt <= done_cnt + 1;
        if (tx_done2 === 1'b1) done_cnt2 <= done_cnt2 + 1;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    task automatic step();
        @(posedge clk_base);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Push one byte into the default instance.
    task automatic applyStimulus(input logic [7:0] b);
        data_in    = b;
        data_valid = 1'b1;
        step();
        data_valid = 1'b0;
    endtask

    // Push one byte into the two-stop-bit instance.
    task automatic applyStimulus2(input logic [7:0] b);
        data_in2    = b;
        data_valid2 = 1'b1;
        step();
        data_valid2 = 1'b0;
    endtask

    // One bit_clk period (4 high, 4 low); laser levels sampled the cycle after the tick.
    task automatic bitTick(output logic lo, output logic lo2);
        bit_clk = 1'b1;
        step();
        lo  = laser_out;
        lo2 = laser_out2;
        repeat (3) step();
        bit_clk = 1'b0;
        repeat (4) step();
    endtask

    // Run n ticks, shifting each sample in so the first bit ends up most significant.
    task automatic collectTicks(input int n, output logic [63:0] b1, output logic [63:0] b2);
        logic lo;
        logic lo2;
        b1 = '0;
        b2 = '0;
        for (int i = 0; i < n; i++) begin
            bitTick(lo, lo2);
            b1 = {b1[62:0], lo};
            b2 = {b2[62:0], lo2};
        end
    endtask

    // Directed sequence covering reset, framing, back-to-back, full FIFO, abort and reset.
    initial begin
        tests       = 0;
        failed      = 0;
        reset       = 1'b1;
        en          = 1'b1;
        bit_clk     = 1'b0;
        data_in     = 8'h00;
        data_valid  = 1'b0;
        data_in2    = 8'h00;
        data_valid2 = 1'b0;
        repeat (2) step();

        checkOutput("rst_laser", laser_out, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_ready", data_ready, 1'b1);
        checkOutput("rst_count", fifo_count, 3'd0);
        checkOutput("rst_done", tx_done, 1'b0);
        checkOutput("rst_laser2", laser_out2, 1'b1);
        reset = 1'b0;
        step();

        // Single frame of 0xA5.
        applyStimulus(8'hA5);
        checkOutput("t1_count_after_push", fifo_count, 3'd1);
        base = done_cnt;
        collectTicks(10, bits, bits2);
        checkOutput("t1_frame", bits[9:0], 10'b1101001010);
        checkOutput("t1_busy_in_stop", busy, 1'b1);
        checkOutput("t1_count_popped", fifo_count, 3'd0);
        checkOutput("t1_done_not_yet", done_cnt - base, 0);
        collectTicks(1, bits, bits2);
        checkOutput("t1_idle_level", bits[0], 1'b0);
        checkOutput("t1_done_once", done_cnt - base, 1);
        checkOutput("t1_busy_fall", busy, 1'b0);

        // Three frames back-to-back with no idle gap.
        applyStimulus(8'h00);
        applyStimulus(8'hFF);
        applyStimulus(8'h3C);
        checkOutput("t2_count", fifo_count, 3'd3);
        base = done_cnt;
        collectTicks(30, bits, bits2);
        checkOutput("t2_frames", bits[29:0], {10'b1000000000, 10'b1111111110, 10'b1001111000});
        collectTicks(1, bits, bits2);
        checkOutput("t2_done_three", done_cnt - base, 3);
        checkOutput("t2_busy_fall", busy, 1'b0);

        // Fill the FIFO while disabled; the fifth byte must be refused.
        en = 1'b0;
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        applyStimulus(8'h33);
        applyStimulus(8'h44);
        checkOutput("t3_ready_full", data_ready, 1'b0);
        checkOutput("t3_count_full", fifo_count, 3'd4);
        applyStimulus(8'h55);
        checkOutput("t3_count_still_full", fifo_count, 3'd4);
        checkOutput("t3_idle_disabled", busy, 1'b0);
        en = 1'b1;
        base = done_cnt;
        collectTicks(40, bits, bits2);
        checkOutput("t3_frame_11", bits[39:30], 10'b1100010000);
        checkOutput("t3_frame_22", bits[29:20], 10'b1010001000);
        checkOutput("t3_frame_33", bits[19:10], 10'b1110011000);
        checkOutput("t3_frame_44", bits[9:0], 10'b1001000100);
        collectTicks(1, bits, bits2);
        checkOutput("t3_done_four", done_cnt - base, 4);
        checkOutput("t3_count_empty", fifo_count, 3'd0);
        checkOutput("t3_ready_again", data_ready, 1'b1);

        // Abort 0x81 during data bit 3, then send 0x42.
        applyStimulus(8'h81);
        applyStimulus(8'h42);
        checkOutput("t4_count", fifo_count, 3'd2);
        base = done_cnt;
        collectTicks(5, bits, bits2);
        checkOutput("t4_partial", bits[4:0], 5'b11000);
        checkOutput("t4_busy_before", busy, 1'b1);
        en = 1'b0;
        step();
        checkOutput("t4_abort_laser", laser_out, 1'b0);
        checkOutput("t4_abort_busy", busy, 1'b0);
        checkOutput("t4_abort_count", fifo_count, 3'd1);
        collectTicks(3, bits, bits2);
        checkOutput("t4_disabled_idle", bits[2:0], 3'b000);
        checkOutput("t4_no_done", done_cnt - base, 0);
        en = 1'b1;
        collectTicks(10, bits, bits2);
        checkOutput("t4_next_frame", bits[9:0], 10'b1010000100);
        collectTicks(1, bits, bits2);
        checkOutput("t4_done_once", done_cnt - base, 1);
        checkOutput("t4_count_empty", fifo_count, 3'd0);

        // Asynchronous reset mid-frame with two bytes still queued.
        applyStimulus(8'hAA);
        applyStimulus(8'hBB);
        applyStimulus(8'hCC);
        collectTicks(3, bits, bits2);
        checkOutput("t5_partial", bits[2:0], 3'b101);
        checkOutput("t5_count_before", fifo_count, 3'd2);
        reset = 1'b1;
        #1;
        checkOutput("t5_async_laser", laser_out, 1'b0);
        checkOutput("t5_async_count", fifo_count, 3'd0);
        checkOutput("t5_async_busy", busy, 1'b0);
        step();
        reset = 1'b0;
        step();
        base = done_cnt;
        collectTicks(20, bits, bits2);
        checkOutput("t5_quiet_laser", bits[19:0], 20'h00000);
        checkOutput("t5_quiet_laser2", bits2[19:0], 20'hFFFFF);
        checkOutput("t5_no_done", done_cnt - base, 0);
        checkOutput("t5_count_empty", fifo_count, 3'd0);

        // Two stop bits, idle-high polarity, byte 0x55.
        base2 = done_cnt2;
        applyStimulus2(8'h55);
        checkOutput("t6_count", fifo_count2, 3'd1);
        collectTicks(11, bits, bits2);
        checkOutput("t6_frame", bits2[10:0], 11'b01010101011);
        checkOutput("t6_busy_2nd_stop", busy2, 1'b1);
        checkOutput("t6_done_not_yet", done_cnt2 - base2, 0);
        collectTicks(1, bits, bits2);
        checkOutput("t6_idle_high", bits2[0], 1'b1);
        checkOutput("t6_done_once", done_cnt2 - base2, 1);
        checkOutput("t6_busy_fall", busy2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
